// File: rtl/muldiv_unit.sv
// muldiv_unit: RV32M multiply/divide unit; single-cycle or shift-add multiply, restoring divide.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_MODE = 0
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          f3_q;
  logic                neg_q;
  logic [XLEN-1:0]     a_q, b_q, result_q;
  logic [2*XLEN-1:0]   prod_q, prod_d, full;
  logic                a_sgn, b_sgn, neg, div0, ovf;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mstep, shifted, diff;
  // prod_q is {partial, multiplier} while multiplying and {remainder, quotient} while dividing
  function automatic logic [XLEN-1:0] sel(input logic [2:0] f, input logic ng, input logic [2*XLEN-1:0] p);
    logic [2*XLEN-1:0] pp;
    pp = ng ? -p : p;
    return (!f[2] && f[1:0] != 2'b00) ? pp[2*XLEN-1:XLEN] :
           (f[2] && f[1]) ? (ng ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN]) : pp[XLEN-1:0];
  endfunction
  always_comb begin
    a_sgn   = opA[XLEN-1] & (func3 == 3'b001 || func3 == 3'b010 || func3 == 3'b100 || func3 == 3'b110);
    b_sgn   = opB[XLEN-1] & (func3 == 3'b001 || func3 == 3'b100 || func3 == 3'b110);
    mag_a   = a_sgn ? -opA : opA;
    mag_b   = b_sgn ? -opB : opB;
    neg     = (func3 == 3'b110) ? a_sgn : a_sgn ^ b_sgn;
    div0    = func3[2] && opB == '0;
    ovf     = func3[2] && !func3[0] && opA == {1'b1, {(XLEN-1){1'b0}}} && &opB;
    full    = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
    mstep   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    shifted = prod_q[2*XLEN-1:XLEN-1];
    diff    = shifted - {1'b0, b_q};
    prod_d  = (state_q == MUL) ? {mstep, prod_q[XLEN-1:1]} :
              {diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0], prod_q[XLEN-2:0], ~diff[XLEN]};
  end
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      result_q <= '0;
    end else if (kill) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          f3_q  <= func3;
          neg_q <= neg;
          a_q   <= mag_a;
          b_q   <= mag_b;
          cnt_q <= CW'(XLEN);
          if (!func3[2]) begin
            if (MUL_MODE == 0) begin
              result_q <= sel(func3, neg, full);
              state_q  <= DONE;
            end else begin
              prod_q  <= {{XLEN{1'b0}}, mag_b};
              state_q <= MUL;
            end
          end else if (div0 || ovf) begin
            result_q <= div0 ? (func3[1] ? opA : '1) : (func3[1] ? '0 : opA);
            state_q  <= DONE;
          end else begin
            prod_q  <= {{XLEN{1'b0}}, mag_a};
            state_q <= DIV;
          end
        end
        MUL, DIV: begin
          prod_q <= prod_d;
          cnt_q  <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= sel(f3_q, neg_q, prod_d);
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy   = state_q == MUL || state_q == DIV;
  assign done   = state_q == DONE;
  assign result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors against both multiply modes plus kill, held-start and clear sequences.
module tb_muldiv_unit;
  logic        clock, clear, start, kill;
  logic [2:0]  func3;
  logic [31:0] opA, opB, result0, result1;
  logic        busy0, done0, busy1, done1;
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int          lat0, lat1;
  } vec_t;
  vec_t tbl[19];
  muldiv_unit #(.XLEN(32), .MUL_MODE(0)) u0 (
    .clock(clock), .clear(clear), .start(start), .func3(func3), .opA(opA), .opB(opB),
    .kill(kill), .busy(busy0), .done(done0), .result(result0));
  muldiv_unit #(.XLEN(32), .MUL_MODE(1)) u1 (
    .clock(clock), .clear(clear), .start(start), .func3(func3), .opA(opA), .opB(opB),
    .kill(kill), .busy(busy1), .done(done1), .result(result1));
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     output int l0, output int l1, output logic [31:0] r0, output logic [31:0] r1,
                     output int bz0, output int bz1);
    @(negedge clock);
    func3 = f; opA = a; opB = b; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    l0 = 0; l1 = 0; bz0 = 0; bz1 = 0; r0 = 'x; r1 = 'x;
    for (int c = 1; c <= 40 && (l0 == 0 || l1 == 0); c++) begin
      if (busy0) bz0++;
      if (busy1) bz1++;
      if (done0 && l0 == 0) begin l0 = c; r0 = result0; end
      if (done1 && l1 == 0) begin l1 = c; r1 = result1; end
      @(posedge clock);
      #1;
    end
  endtask
  initial begin
    int l0, l1, bz0, bz1, n, c1, c2;
    logic [31:0] r0, r1, prev;
    tbl[0]  = '{3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1, 33};
    tbl[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1, 33};
    tbl[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 33};
    tbl[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1, 33};
    tbl[4]  = '{3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 1, 33};
    tbl[5]  = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1, 33};
    tbl[6]  = '{3'b001, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1, 33};
    tbl[7]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 33};
    tbl[8]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 33};
    tbl[9]  = '{3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33, 33};
    tbl[10] = '{3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33, 33};
    tbl[11] = '{3'b101, 32'd100,      32'd7,        32'd14,       33, 33};
    tbl[12] = '{3'b111, 32'd100,      32'd7,        32'd2,        33, 33};
    tbl[13] = '{3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1};
    tbl[14] = '{3'b111, 32'd5,        32'd0,        32'd5,        1, 1};
    tbl[15] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1};
    tbl[16] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 1};
    tbl[17] = '{3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1, 1};
    tbl[18] = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1};
    clear = 1'b0; start = 1'b0; kill = 1'b0; func3 = '0; opA = '0; opB = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset busy", 32'(busy0), 0);
    chk("reset done", 32'(done0), 0);
    chk("reset result", result0, 0);
    chk("reset result m1", result1, 0);
    clear = 1'b1;
    foreach (tbl[i]) begin
      run(tbl[i].f, tbl[i].a, tbl[i].b, l0, l1, r0, r1, bz0, bz1);
      chk($sformatf("v%0d result m0", i), r0, tbl[i].exp);
      chk($sformatf("v%0d result m1", i), r1, tbl[i].exp);
      chk($sformatf("v%0d latency m0", i), l0, tbl[i].lat0);
      chk($sformatf("v%0d latency m1", i), l1, tbl[i].lat1);
      chk($sformatf("v%0d busy cycles m0", i), bz0, tbl[i].lat0 - 1);
      chk($sformatf("v%0d busy cycles m1", i), bz1, tbl[i].lat1 - 1);
    end
    prev = tbl[18].exp;
    // kill during the 10th busy cycle of a divide
    @(negedge clock);
    func3 = 3'b100; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    chk("kill pre busy", 32'(busy0), 1);
    kill = 1'b1;
    @(posedge clock);
    #1 kill = 1'b0;
    chk("kill busy", 32'(busy0), 0);
    chk("kill done", 32'(done0), 0);
    chk("kill result", result0, prev);
    chk("kill result m1", result1, prev);
    n = 0;
    repeat (40) begin
      if (done0 || done1) n++;
      @(posedge clock);
      #1;
    end
    chk("kill no done", n, 0);
    // start held high through busy: relaunch only after returning to IDLE
    @(negedge clock);
    func3 = 3'b101; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(posedge clock);
    #1 opA = 32'd200;
    n = 0; c1 = 0; c2 = 0; r0 = 'x; r1 = 'x;
    for (int c = 1; c <= 90 && n < 2; c++) begin
      if (done0) begin
        n++;
        if (n == 1) begin c1 = c; r0 = result0; end
        else begin c2 = c; r1 = result0; start = 1'b0; end
      end
      if (n < 2) begin
        @(posedge clock);
        #1;
      end
    end
    start = 1'b0;
    chk("held first latency", c1, 33);
    chk("held first result", r0, 32'd14);
    chk("held relaunch result", r1, 32'd28);
    chk("held relaunch after idle", 32'(c2 > c1 + 2), 1);
    repeat (2) @(posedge clock);
    // clear in the middle of a divide
    @(negedge clock);
    func3 = 3'b100; opA = 32'd100; opB = 32'd7; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #1 clear = 1'b0;
    @(posedge clock);
    #1 clear = 1'b1;
    chk("clear busy", 32'(busy0), 0);
    chk("clear done", 32'(done0), 0);
    chk("clear result", result0, 0);
    chk("clear busy m1", 32'(busy1), 0);
    run(3'b011, 32'hFFFFFFFF, 32'd2, l0, l1, r0, r1, bz0, bz1);
    chk("post clear mulhu m0", r0, 32'd1);
    chk("post clear mulhu m1", r1, 32'd1);
    chk("post clear latency m0", l0, 1);
    chk("post clear latency m1", l1, 33);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
